// File: rtl/led_arbiter.sv
// ---------------------------------------------------------------------------
// led_arbiter
//   Round-robin arbiter that hands a pair of board LEDs to one requester at a
//   time. The winner's LEDs alternate (led1/led2) for 2*N phase ticks, where N
//   is the requester's 4-bit blink count latched at grant time; a one-cycle
//   done pulse then reports completion. Dropping the request mid-transfer
//   aborts back to IDLE without a done pulse.
//
// Parameters
//   CLK_DIV  clocks per LED phase tick
//   NREQ     number of requesters
//
// Ports
//   cloooock  in   clock, rising edge
//   reset     in   asynchronous active-high reset
//   req       in   [NREQ]    level request per requester
//   blinks    in   [NREQ*4]  blink count per requester, nibble i = requester i
//   gnt       out  [NREQ]    one-hot grant (GRANT and RUN), else zero
//   done      out  [NREQ]    one-cycle completion pulse
//   busy      out            high in every state except IDLE
//   led1      out            board LED 1
//   led2      out            board LED 2
// ---------------------------------------------------------------------------
module led_arbiter #(
  parameter int CLK_DIV = 2000000,
  parameter int NREQ    = 4
) (
  input  logic              cloooock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*4-1:0] blinks,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic              led1,
  output logic              led2
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, GRANT, RUN, DONE} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   winner_q, winner_d;
  logic [3:0]      n_q, n_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [4:0]      phase_q, phase_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            busy_q, busy_d;
  logic            led1_q, led1_d;
  logic            led2_q, led2_d;

  logic            tick;
  logic [IW-1:0]   next_ptr;
  logic            found;
  logic [IW-1:0]   rr_idx;

  assign tick     = (presc_q == PRESC_MAX);
  assign next_ptr = (winner_q == LAST_IDX) ? '0 : winner_q + IW'(1);

  // Round-robin search: first requester at or after ptr, wrapping.
  // NOTE: combinational blocks use blocking '=' so later statements see the
  // values just computed (the found flag here relies on that).
  always_comb begin
    int idx;
    idx    = 0;
    found  = 1'b0;
    rr_idx = ptr_q;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found  = 1'b1;
        rr_idx = IW'(idx);
      end
    end
  end

  // Next-state logic.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    winner_d = winner_q;
    n_d      = n_q;
    presc_d  = '0;
    phase_d  = phase_q;
    led1_d   = 1'b0;
    led2_d   = 1'b0;

    case (state_q)
      IDLE: begin
        phase_d = '0;
        if (found) begin
          state_d  = GRANT;
          winner_d = rr_idx;
          n_d      = blinks[4*int'(rr_idx) +: 4];
        end
      end

      GRANT: begin
        if (!req[winner_q]) begin
          state_d = IDLE;
          ptr_d   = next_ptr;
        end else if (n_q == 4'd0) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
          phase_d = '0;
          led1_d  = 1'b1;
        end
      end

      RUN: begin
        if (!req[winner_q]) begin
          state_d = IDLE;
          ptr_d   = next_ptr;
        end else begin
          led1_d  = led1_q;
          led2_d  = led2_q;
          presc_d = tick ? '0 : presc_q + PW'(1);
          if (tick) begin
            // The tick that would complete phase 2N ends the run instead of
            // swapping, so RUN spans exactly 2N*CLK_DIV cycles.
            if (phase_q + 5'd1 == {n_q, 1'b0}) begin
              state_d = DONE;
              led1_d  = 1'b0;
              led2_d  = 1'b0;
            end else begin
              led1_d  = led2_q;
              led2_d  = led1_q;
              phase_d = phase_q + 5'd1;
            end
          end
        end
      end

      DONE: begin
        state_d = IDLE;
        ptr_d   = next_ptr;
      end

      default: state_d = IDLE;
    endcase
  end

  // Registered outputs are decoded from the next state so they line up with
  // the state they describe.
  always_comb begin
    gnt_d  = '0;
    done_d = '0;
    if (state_d == GRANT || state_d == RUN) gnt_d[winner_d] = 1'b1;
    if (state_d == DONE) done_d[winner_d] = 1'b1;
    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // its pre-edge inputs, independent of statement order.
  always_ff @(posedge cloooock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      winner_q <= '0;
      n_q      <= '0;
      presc_q  <= '0;
      phase_q  <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      led1_q   <= 1'b0;
      led2_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      winner_q <= winner_d;
      n_q      <= n_d;
      presc_q  <= presc_d;
      phase_q  <= phase_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      led1_q   <= led1_d;
      led2_q   <= led2_d;
    end
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign busy = busy_q;
  assign led1 = led1_q;
  assign led2 = led2_q;

endmodule

// File: tb/tb_led_arbiter.sv
// ---------------------------------------------------------------------------
// tb_led_arbiter
//   Directed bench for led_arbiter with CLK_DIV=4, NREQ=4. A table of
//   back-to-back transfers exercises round-robin order, blink lengths and
//   blink latching; hand-written sequences cover the LED phase pattern,
//   fairness under full load, N=0, abort and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_led_arbiter;

  localparam int CLK_DIV = 4;
  localparam int NREQ    = 4;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] blinks;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        busy;
  logic        led1;
  logic        led2;

  led_arbiter #(.CLK_DIV(CLK_DIV), .NREQ(NREQ)) dut (
    .cloooock (clk),
    .reset    (reset),
    .req      (req),
    .blinks   (blinks),
    .gnt      (gnt),
    .done     (done),
    .busy     (busy),
    .led1     (led1),
    .led2     (led2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    req    = '0;
    blinks = '0;
    repeat (2) @(negedge clk);
    reset  = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [15:0] blinks;
    logic [3:0]  exp_gnt;
    int          exp_lit;
  } vec_t;

  vec_t        vecs[6];
  int          lat, lit, both, gbad, cyc;
  logic [15:0] l1_act, l2_act;
  logic [3:0]  order[5];
  int          start[5];
  int          ng, c, idle;
  logic [3:0]  prev;
  logic        seen_done;

  initial begin
    // Transfers run back to back from reset; ptr carries between entries:
    // 0 -> w0 ptr1 -> w2 ptr3 -> w0 (wrap) ptr1 -> w3 ptr0 -> w2 ptr3 -> w3.
    vecs[0] = '{4'b0001, 16'h0002, 4'b0001, 16};
    vecs[1] = '{4'b0101, 16'h0111, 4'b0100, 8};
    vecs[2] = '{4'b0011, 16'h0031, 4'b0001, 8};
    vecs[3] = '{4'b1000, 16'hF000, 4'b1000, 120};
    vecs[4] = '{4'b0100, 16'h0000, 4'b0100, 0};
    vecs[5] = '{4'b1001, 16'h5002, 4'b1000, 40};

    reset  = 1'b1;
    req    = '0;
    blinks = '0;
    @(negedge clk);
    check("reset_outputs", {20'd0, gnt, done, busy, led1, led2}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("idle_no_req", {20'd0, gnt, done, busy, led1, led2}, 32'd0);

    // ---------------- table-driven transfers ----------------
    for (int v = 0; v < 6; v++) begin
      req    = vecs[v].req;
      blinks = vecs[v].blinks;
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (gnt == 4'd0 && lat < 20);
      check($sformatf("v%0d_gnt_latency", v), lat, 1);
      check($sformatf("v%0d_gnt", v), gnt, vecs[v].exp_gnt);
      // Blink counts must be latched at grant; scramble them now.
      blinks = ~vecs[v].blinks;
      lit = 0; both = 0; gbad = 0; cyc = 0;
      while (done == 4'd0 && cyc < 300) begin
        @(negedge clk);
        cyc++;
        if (done == 4'd0) begin
          if (led1 | led2) lit++;
          if (led1 & led2) both++;
          if (gnt != vecs[v].exp_gnt) gbad++;
        end
      end
      check($sformatf("v%0d_lit_cycles", v), lit, vecs[v].exp_lit);
      check($sformatf("v%0d_leds_exclusive", v), both, 0);
      check($sformatf("v%0d_gnt_stable", v), gbad, 0);
      check($sformatf("v%0d_done", v), done, vecs[v].exp_gnt);
      check($sformatf("v%0d_done_state", v), {28'd0, gnt == 4'd0, busy, led1, led2}, 32'b1100);
      req = '0;
      @(negedge clk);
      check($sformatf("v%0d_after_done", v), {27'd0, done, busy}, 32'd0);
    end

    // ---------------- N=2 LED phase pattern ----------------
    do_reset();
    req    = 4'b0001;
    blinks = 16'h0002;
    @(negedge clk);
    check("pat_grant", {26'd0, gnt, led1, led2}, {26'd0, 4'b0001, 2'b00});
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      l1_act[k] = led1;
      l2_act[k] = led2;
    end
    check("pat_led1", l1_act, 16'h0F0F);
    check("pat_led2", l2_act, 16'hF0F0);
    @(negedge clk);
    check("pat_done", {25'd0, done, busy, led1, led2}, {25'd0, 4'b0001, 3'b100});
    req = '0;
    @(negedge clk);
    check("pat_after", {27'd0, done, busy}, 32'd0);

    // ---------------- fairness under full load ----------------
    do_reset();
    req    = 4'b1111;
    blinks = 16'h1111;
    ng = 0; c = 0; idle = 0; prev = '0;
    while (ng < 5 && c < 100) begin
      @(negedge clk);
      c++;
      if (gnt != 4'd0 && prev == 4'd0) begin
        order[ng] = gnt;
        start[ng] = c;
        ng++;
      end
      if (ng >= 1 && ng < 5 && !busy) idle++;
      prev = gnt;
    end
    req = '0;
    check("rr_grant_count", ng, 5);
    for (int g = 0; g < 5; g++) begin
      check($sformatf("rr_order%0d", g), order[g], 4'b0001 << (g % 4));
      check($sformatf("rr_start%0d", g), start[g], 1 + 11 * g);
    end
    check("rr_idle_gaps", idle, 4);

    // ---------------- N=0 ----------------
    do_reset();
    req    = 4'b0100;
    blinks = 16'h0000;
    @(negedge clk);
    check("n0_grant", {25'd0, gnt, busy, led1, led2}, {25'd0, 4'b0100, 3'b100});
    @(negedge clk);
    check("n0_done", {21'd0, gnt, done, busy, led1, led2}, {21'd0, 4'b0000, 4'b0100, 3'b100});
    req = '0;
    @(negedge clk);
    check("n0_idle", {24'd0, gnt, done}, 32'd0);
    check("n0_idle_busy", busy, 1'b0);

    // ---------------- abort mid-RUN ----------------
    do_reset();
    req    = 4'b0010;
    blinks = 16'h0030;
    @(negedge clk);
    check("ab_grant", gnt, 4'b0010);
    seen_done = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done != 4'd0) seen_done = 1'b1;
    end
    check("ab_running", {30'd0, led1 | led2, busy}, 32'b11);
    req = 4'b0000;
    @(negedge clk);
    if (done != 4'd0) seen_done = 1'b1;
    check("ab_idle", {21'd0, gnt, done, busy, led1, led2}, 32'd0);
    check("ab_no_done", seen_done, 1'b0);
    req    = 4'b1111;
    blinks = 16'h0000;
    @(negedge clk);
    check("ab_ptr_next", gnt, 4'b0100);
    req = '0;
    repeat (3) @(negedge clk);

    // ---------------- async reset mid-RUN ----------------
    do_reset();
    req    = 4'b0001;
    blinks = 16'h0002;
    repeat (3) @(negedge clk);
    check("rst_running", {27'd0, gnt, led1}, {27'd0, 4'b0001, 1'b1});
    #2;
    reset = 1'b1;
    #1;
    check("rst_async_clear", {20'd0, gnt, done, busy, led1, led2}, 32'd0);
    reset  = 1'b0;
    req    = 4'b1010;
    blinks = 16'h0000;
    @(negedge clk);
    check("rst_rearb", gnt, 4'b0010);
    check("rst_no_done", done, 4'd0);
    req = '0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
